// File: rtl/buzz_seq_ctrl.sv
// Tone scheduler: queues key codes 1-4 in a 4-entry FIFO and plays each one
// as a fixed-length square-wave note on the buzzer, with a silent gap after every note.
module buzz_seq_ctrl #(
  parameter int CNT_W       = 24,
  parameter int TONE_HALF_1 = 95_419,
  parameter int TONE_HALF_2 = 85_034,
  parameter int TONE_HALF_3 = 75_757,
  parameter int TONE_HALF_4 = 71_633,
  parameter int NOTE_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_val,
  input  logic       clear,
  output logic       buzz,
  output logic       busy,
  output logic [2:0] cur_code,
  output logic [2:0] fifo_cnt,
  output logic       overflow
);

  // Handshake: a request is any cycle with key_val in 1..4. It is accepted
  // when the FIFO has room, or when the FSM pops the head in that same cycle.
  // It is dropped otherwise, and overflow pulses in the following cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_next;
  logic [2:0]       fifo_mem [4];
  logic [1:0]       wr_ptr, rd_ptr;
  logic [2:0]       cnt_next;
  logic [CNT_W-1:0] dur_cnt, dur_next;
  logic [CNT_W-1:0] half_cnt, half_next;
  logic             buzz_next;
  logic [2:0]       code_next;
  logic             req, pop, push, drop;

  function automatic logic [CNT_W-1:0] half_last(input logic [2:0] code);
    case (code)
      3'd2:    half_last = CNT_W'(TONE_HALF_2 - 1);
      3'd3:    half_last = CNT_W'(TONE_HALF_3 - 1);
      3'd4:    half_last = CNT_W'(TONE_HALF_4 - 1);
      default: half_last = CNT_W'(TONE_HALF_1 - 1);
    endcase
  endfunction

  // FIFO control; clear discards any request of its own cycle.
  always_comb begin
    req  = (key_val != 3'd0) && (key_val <= 3'd4);
    pop  = (state == IDLE) && (fifo_cnt != 3'd0) && !clear;
    push = req && !clear && ((fifo_cnt != 3'd4) || pop);
    drop = req && !clear && (fifo_cnt == 3'd4) && !pop;
    cnt_next = fifo_cnt;
    if (clear) begin
      cnt_next = 3'd0;
    end else if (push && !pop) begin
      cnt_next = fifo_cnt + 3'd1;
    end else if (pop && !push) begin
      cnt_next = fifo_cnt - 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    dur_next   = dur_cnt;
    half_next  = half_cnt;
    buzz_next  = buzz;
    code_next  = cur_code;
    case (state)
      IDLE: begin
        buzz_next = 1'b0;
        code_next = 3'd0;
        dur_next  = '0;
        half_next = '0;
        if (pop) begin
          state_next = PLAY;
          code_next  = fifo_mem[rd_ptr];
        end
      end
      PLAY: begin
        dur_next = dur_cnt + 1'b1;
        if (half_cnt == half_last(cur_code)) begin
          half_next = '0;
          buzz_next = ~buzz;
        end else begin
          half_next = half_cnt + 1'b1;
        end
        // The note ends low regardless of where the toggle phase is.
        if (dur_cnt == NOTE_LAST) begin
          state_next = GAP;
          buzz_next  = 1'b0;
          code_next  = 3'd0;
          dur_next   = '0;
          half_next  = '0;
        end
      end
      GAP: begin
        buzz_next = 1'b0;
        dur_next  = dur_cnt + 1'b1;
        if (dur_cnt == GAP_LAST) begin
          state_next = IDLE;
          dur_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        buzz_next  = 1'b0;
        code_next  = 3'd0;
        dur_next   = '0;
        half_next  = '0;
      end
    endcase
    if (clear) begin
      state_next = IDLE;
      buzz_next  = 1'b0;
      code_next  = 3'd0;
      dur_next   = '0;
      half_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      half_cnt <= '0;
      buzz     <= 1'b0;
      cur_code <= 3'd0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      fifo_cnt <= 3'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= 3'd0;
      end
    end else begin
      state    <= state_next;
      dur_cnt  <= dur_next;
      half_cnt <= half_next;
      buzz     <= buzz_next;
      cur_code <= code_next;
      busy     <= (state_next != IDLE) || (cnt_next != 3'd0);
      overflow <= drop;
      fifo_cnt <= cnt_next;
      if (clear) begin
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= key_val;
          wr_ptr           <= wr_ptr + 2'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_buzz_seq_ctrl.sv
// Bench for buzz_seq_ctrl: directed scenarios plus random key/clear traffic,
// checked every cycle against a note-timeline model and a played-note scoreboard.
module tb_buzz_seq_ctrl;

  localparam int NOTE = 20;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] key_val = 3'd0;
  logic       clear = 1'b0;
  logic       buzz, busy, overflow;
  logic [2:0] cur_code, fifo_cnt;

  buzz_seq_ctrl #(
    .CNT_W(24), .TONE_HALF_1(2), .TONE_HALF_2(3), .TONE_HALF_3(4),
    .TONE_HALF_4(5), .NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .key_val(key_val), .clear(clear), .buzz(buzz),
    .busy(busy), .cur_code(cur_code), .fifo_cnt(fifo_cnt), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", 0, 1);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [2:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_age is the number of cycles since the current note began (-1 = idle).
  int m_q[$];
  int m_age = -1;
  int m_code = 0;
  bit m_ovf = 0;

  function automatic int half_of(input int code);
    return code + 1;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_age = -1;
    m_code = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_step(input int k, input bit c);
    if (c) begin
      model_reset();
      return;
    end
    if (m_age < 0) begin
      if (m_q.size() > 0) begin
        m_code = m_q.pop_front();
        m_age = 0;
        exp_q.push_back(3'(m_code));
      end
    end else begin
      m_age++;
      if (m_age == NOTE + GAP) m_age = -1;
    end
    m_ovf = 0;
    if (k >= 1 && k <= 4) begin
      if (m_q.size() < 4) m_q.push_back(k);
      else m_ovf = 1;
    end
  endfunction

  // ---------------- observation stats ----------------
  int cyc = 0;
  int rises = 0;
  int ovf_pulses = 0;
  int peak = 0;
  int obs[$];
  int starts[$];
  logic prev_buzz = 1'b0;
  logic [2:0] prev_code = 3'd0;

  task automatic reset_stats();
    rises = 0;
    ovf_pulses = 0;
    peak = 0;
    obs.delete();
    starts.delete();
  endtask

  task automatic compare();
    bit   play;
    logic [31:0] e_buzz;
    play = (m_age >= 0) && (m_age < NOTE);
    e_buzz = play ? 32'((m_age / half_of(m_code)) % 2) : 32'd0;
    check_val("cur_code", cur_code, play ? m_code : 0);
    check_val("buzz", buzz, e_buzz);
    check_val("fifo_cnt", fifo_cnt, m_q.size());
    check_val("busy", busy, (m_age >= 0 || m_q.size() > 0) ? 1 : 0);
    check_val("overflow", overflow, m_ovf);
    if (buzz && !prev_buzz) rises++;
    if (overflow) ovf_pulses++;
    if (fifo_cnt > peak) peak = fifo_cnt;
    if (cur_code != 3'd0 && prev_code == 3'd0) begin
      obs.push_back(cur_code);
      starts.push_back(cyc);
      if (exp_q.size() == 0) check_val("note_unexpected", cur_code, 0);
      else check_val("note_order", cur_code, exp_q.pop_front());
    end
    prev_buzz = buzz;
    prev_code = cur_code;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [2:0] k, input logic c);
    key_val = k;
    clear = c;
    @(posedge clk);
    model_step(k, c);
    cyc++;
    @(negedge clk);
    key_val = 3'd0;
    clear = 1'b0;
    compare();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((m_age >= 0 || m_q.size() > 0) && n < limit) begin
      tick(3'd0, 1'b0);
      n++;
    end
    check_val("drain_bound", (n < limit) ? 1 : 0, 1);
    tick(3'd0, 1'b0);
  endtask

  task automatic wait_age(input int age, input int limit, input string tag);
    int n = 0;
    while (m_age != age && n < limit) begin
      tick(3'd0, 1'b0);
      n++;
    end
    check_val(tag, (n < limit) ? 1 : 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_buzz"}, buzz, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_code"}, cur_code, 0);
    check_val({tag, "_cnt"}, fifo_cnt, 0);
    check_val({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    check_all_zero("async_rst_hold");
    rst = 1'b1;
    prev_buzz = 1'b0;
    prev_code = 3'd0;
  endtask

  function automatic int obs_at(input int i);
    return (obs.size() > i) ? obs[i] : -1;
  endfunction

  function automatic int start_at(input int i);
    return (starts.size() > i) ? starts[i] : -1000;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic [2:0] k;
    logic c;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // single press of code 1
    reset_stats();
    base = cyc;
    tick(3'd1, 1'b0);
    drain(60);
    check_val("s1_rises", rises, 5);
    check_val("s1_notes", obs.size(), 1);
    check_val("s1_code", obs_at(0), 1);
    check_val("s1_start", start_at(0) - base, 2);

    // three consecutive presses
    reset_stats();
    base = cyc;
    tick(3'd2, 1'b0);
    tick(3'd3, 1'b0);
    tick(3'd4, 1'b0);
    drain(120);
    check_val("s2_order0", obs_at(0), 2);
    check_val("s2_order1", obs_at(1), 3);
    check_val("s2_order2", obs_at(2), 4);
    check_val("s2_start", start_at(0) - base, 2);
    check_val("s2_space01", start_at(1) - start_at(0), NOTE + GAP + 1);
    check_val("s2_space12", start_at(2) - start_at(1), NOTE + GAP + 1);
    check_val("s2_peak", peak, 2);

    // six presses: one popped, four queued, one dropped
    reset_stats();
    foreach (obs[i]) ; // no-op keeps obs untouched
    tick(3'd1, 1'b0);
    tick(3'd2, 1'b0);
    tick(3'd3, 1'b0);
    tick(3'd4, 1'b0);
    tick(3'd1, 1'b0);
    tick(3'd2, 1'b0);
    drain(200);
    check_val("s3_ovf_pulses", ovf_pulses, 1);
    check_val("s3_notes", obs.size(), 5);
    check_val("s3_peak", peak, 4);

    // press while full in the same cycle as the IDLE pop
    reset_stats();
    tick(3'd1, 1'b0);
    tick(3'd2, 1'b0);
    tick(3'd3, 1'b0);
    tick(3'd4, 1'b0);
    tick(3'd1, 1'b0);
    wait_age(-1, 60, "s4_wait_idle");
    check_val("s4_full_pre", fifo_cnt, 4);
    tick(3'd3, 1'b0);
    check_val("s4_full_post", fifo_cnt, 4);
    check_val("s4_no_ovf", overflow, 0);
    drain(200);
    check_val("s4_ovf_pulses", ovf_pulses, 0);
    check_val("s4_notes", obs.size(), 6);
    check_val("s4_last", obs_at(5), 3);

    // ignored codes
    reset_stats();
    tick(3'd6, 1'b0);
    tick(3'd0, 1'b0);
    tick(3'd7, 1'b0);
    tick(3'd5, 1'b0);
    repeat (3) tick(3'd0, 1'b0);
    check_val("s5_cnt", fifo_cnt, 0);
    check_val("s5_ovf", ovf_pulses, 0);
    check_val("s5_rises", rises, 0);
    check_val("s5_busy", busy, 0);

    // clear at PLAY cycle 7 with two entries queued
    reset_stats();
    tick(3'd1, 1'b0);
    tick(3'd2, 1'b0);
    tick(3'd3, 1'b0);
    wait_age(7, 20, "s6_wait_play7");
    check_val("s6_queued", fifo_cnt, 2);
    tick(3'd4, 1'b1);
    check_all_zero("s6_clear");
    repeat (30) tick(3'd0, 1'b0);
    check_val("s6_notes", obs.size(), 1);

    // asynchronous reset in the middle of GAP
    reset_stats();
    tick(3'd4, 1'b0);
    tick(3'd2, 1'b0);
    wait_age(NOTE + 1, 40, "s7_wait_gap");
    check_val("s7_in_gap_buzz", buzz, 0);
    async_reset();
    repeat (30) tick(3'd0, 1'b0);
    check_val("s7_notes", obs.size(), 1);

    // random traffic
    reset_stats();
    for (int i = 0; i < 1500; i++) begin
      k = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      c = ($urandom_range(0, 199) == 0);
      tick(k, c);
    end
    drain(200);
    check_val("rand_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/buzz_seq_ctrl.md
# buzz_seq_ctrl

Tone scheduler that sits between the debounced key decoder and the board buzzer. It accepts one-cycle key codes (1–4) and queues them in a 4-entry FIFO. It plays each queued code as a fixed-length square-wave note on the single buzzer output, with a silent gap between notes, so that rapid key presses share the buzzer in arrival order instead of cutting each other off.

## Interface
- CNT_W, 24, width of all duration/half-period counters
- TONE_HALF_1, 95_419, half-period in clk cycles for code 1 (≈262 Hz at 50 MHz)
- TONE_HALF_2, 85_034, half-period for code 2 (≈294 Hz)
- TONE_HALF_3, 75_757, half-period for code 3 (≈330 Hz)
- TONE_HALF_4, 71_633, half-period for code 4 (≈349 Hz)
- NOTE_CYCLES, 12_500_000, note length in cycles (250 ms)
- GAP_CYCLES, 2_500_000, silence after each note in cycles (50 ms)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- key_val  in  3  key code; 0 = none, 1–4 = request, held nonzero for a single cycle per press
- clear  in  1  synchronous flush: empties the FIFO, aborts the current note
- buzz  out  1  buzzer drive, registered
- busy  out  1  high when state ≠ IDLE or FIFO non-empty
- cur_code  out  3  code being played; 0 outside PLAY
- fifo_cnt  out  3  number of queued entries, 0–4
- overflow  out  1  one-cycle pulse when a request is dropped

## Operation
- Reset (rst low): state IDLE, FIFO empty, wr/rd pointers 0, buzz=0, busy=0, cur_code=0, fifo_cnt=0, overflow=0, all counters 0.
- Request: key_val in 1–4 in any cycle. Codes 5–7 are ignored silently, with no overflow.
- Push: a request is written at the tail when fifo_cnt<4. A request arriving when fifo_cnt=4 with no pop in the same cycle is dropped, and overflow pulses in the following cycle.
- Simultaneous push and pop: both take effect and fifo_cnt is unchanged. This holds when full, so the request is accepted.
- Pointers are 2 bits and wrap 3→0. fifo_cnt is a separate 3-bit counter.
- FSM states:
  - IDLE: if fifo_cnt>0, pop the head into cur_code, clear the counters, and go to PLAY. Otherwise stay.
  - PLAY: the duration counter increments each cycle. The half-period counter increments, and when it reaches TONE_HALF_cur−1 it resets to 0 and buzz toggles. When the duration counter reaches NOTE_CYCLES−1, go to GAP with buzz=0 and cur_code=0.
  - GAP: buzz held 0. When the counter reaches GAP_CYCLES−1, go to IDLE.
- clear has priority over everything except rst. It takes effect at the next edge: FIFO emptied, state IDLE, buzz=0, cur_code=0, counters 0. A request in the same cycle as clear is discarded.
- buzz is 0 in IDLE and GAP, always. A note always ends with buzz forced low, whatever the toggle phase.

## Timing
- Request in cycle N with FSM in IDLE and FIFO empty:
  - fifo_cnt=1 in cycle N+1.
  - Pop at the end of N+1, so PLAY and cur_code are valid from cycle N+2, and fifo_cnt=0 in N+2.
- First buzz rise is at the start of PLAY cycle TONE_HALF_k (counting the first PLAY cycle as 0). After that, buzz toggles every TONE_HALF_k cycles.
- PLAY lasts exactly NOTE_CYCLES cycles and GAP exactly GAP_CYCLES cycles. IDLE lasts a minimum of 1 cycle between notes.
- Note-start to note-start period with a backlogged queue is NOTE_CYCLES+GAP_CYCLES+1.
- overflow is registered, high for exactly 1 cycle per dropped request.
- busy and fifo_cnt are registered and reflect the post-edge state.
- Asynchronous reset mid-note: all outputs go to their reset values immediately, and the queue is lost.

## Test plan
Bench parameters: TONE_HALF_1..4 = 2,3,4,5; NOTE_CYCLES = 20; GAP_CYCLES = 4.
- Single press, key_val=1 in cycle 0 → PLAY from cycle 2, cur_code=1; buzz rises in cycle 4 and toggles every 2 cycles, giving 5 rises; buzz=0 and GAP from cycle 22; IDLE in cycle 26; busy low from cycle 26.
- Presses 2,3,4 on consecutive cycles → notes played in order 2,3,4; note starts spaced 25 cycles apart; buzz half-periods of 3, 4 and 5 cycles respectively; fifo_cnt peaks at 2.
- Six presses 1,2,3,4,1,2 on consecutive cycles while IDLE → the first is popped, four are queued, and the sixth is dropped. overflow pulses once, and exactly 5 notes are played.
- Press when fifo_cnt=4 in the same cycle as the IDLE pop → the request is accepted, fifo_cnt stays 4, and no overflow occurs.
- key_val=6 and key_val=0 → no FIFO change, no overflow, buzz stays 0.
- clear asserted at PLAY cycle 7 with 2 entries queued → next cycle: IDLE, buzz=0, fifo_cnt=0, busy=0. A rst pulse mid-GAP gives all outputs 0 asynchronously.
